// File: rtl/or1200_wb_arbiter.sv
// Two-master Wishbone arbiter: round-robin grant of one shared slave port,
// with a stall watchdog that ends a hung strobe with an error.
module or1200_wb_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,

    output logic [1:0]      gnt_o,
    output logic            busy_o
);

    // state | meaning
    // IDLE  | no grant held, slave port quiet
    // GNT0  | master 0 (instruction) owns the slave port
    // GNT1  | master 1 (data) owns the slave port
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       last_gnt;           // 1: master 1 was granted most recently
    logic [7:0] tmo_cnt, tmo_cnt_nxt;
    logic       tmo_hit;

    assign tmo_hit = (state != IDLE) && (tmo_cnt == 8'(TIMEOUT));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            tmo_cnt  <= 8'd0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            if ((state_nxt != IDLE) && (state_nxt != state))
                last_gnt <= (state_nxt == GNT1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    state_nxt = last_gnt ? GNT0 : GNT1;
                else if (m0_cyc_i)
                    state_nxt = GNT0;
                else if (m1_cyc_i)
                    state_nxt = GNT1;
            end
            GNT0: begin
                if (!m0_cyc_i)
                    state_nxt = m1_cyc_i ? GNT1 : IDLE;
            end
            GNT1: begin
                if (!m1_cyc_i)
                    state_nxt = m0_cyc_i ? GNT0 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        gnt_o    = 2'b00;
        case (state)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & ~tmo_hit;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_ack_o = s_ack_i & ~s_err_i & ~tmo_hit;
                m0_err_o = s_err_i | tmo_hit;
                gnt_o    = 2'b01;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & ~tmo_hit;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_ack_o = s_ack_i & ~s_err_i & ~tmo_hit;
                m1_err_o = s_err_i | tmo_hit;
                gnt_o    = 2'b10;
            end
            default: ;
        endcase
    end

    // A grant change or a watchdog firing restarts the stall count.
    always_comb begin
        if ((state_nxt != state) || tmo_hit)
            tmo_cnt_nxt = 8'd0;
        else if (s_stb_o && !s_ack_i && !s_err_i)
            tmo_cnt_nxt = tmo_cnt + 8'd1;
        else
            tmo_cnt_nxt = 8'd0;
    end

    assign busy_o   = |gnt_o;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: doc/or1200_wb_arbiter.md
OR1200_WB_ARBITER -- requirements
Module: or1200_wb_arbiter

Interface
REQ-001 SHALL have parameter AW, 32, address width.
REQ-002 SHALL have parameter DW, 32, data width; select width is DW/8.
REQ-003 SHALL have parameter TIMEOUT, 255, number of stalled strobe cycles before the arbiter terminates a transfer with an error (1..255).
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports clk_i and rst_i.
REQ-005 Clock: clk_i, input, 1, system clock; all state changes on its rising edge.
REQ-006 Reset: rst_i, input, 1, asynchronous active-high reset.
REQ-007 Master 0 (instruction) inputs: m0_cyc_i 1, m0_stb_i 1, m0_we_i 1, m0_adr_i AW, m0_dat_i DW, m0_sel_i DW/8.
REQ-008 Master 0 outputs: m0_dat_o DW, m0_ack_o 1, m0_err_o 1.
REQ-009 Master 1 (data) uses the same port set with an m1_ prefix.
REQ-010 Slave outputs: s_cyc_o 1, s_stb_o 1, s_we_o 1, s_adr_o AW, s_dat_o DW, s_sel_o DW/8.
REQ-011 Slave inputs: s_dat_i DW, s_ack_i 1, s_err_i 1.
REQ-012 Status outputs: gnt_o, output, 2, one-hot grant ({m1,m0}); busy_o, output, 1, high when any grant is held.

Function
REQ-013 SHALL implement the state machine IDLE, GNT0, GNT1, with state, last-grant and timeout counter registered.
REQ-014 IDLE: m0_cyc_i only -> GNT0; m1_cyc_i only -> GNT1; both -> grant the master not granted last (round-robin); neither -> stay in IDLE.
REQ-015 The grant SHALL be visible one cycle after a request is sampled in IDLE, and s_cyc_o SHALL not be asserted in IDLE.
REQ-016 GNTx: s_cyc/stb/we/adr/dat/sel_o SHALL be combinationally driven from master x.
REQ-017 GNTx: s_ack_i and s_err_i SHALL route only to mx_ack_o/mx_err_o; the other master's ack/err SHALL be 0.
REQ-018 m0_dat_o and m1_dat_o SHALL both equal s_dat_i at all times.
REQ-019 The grant SHALL be held while mx_cyc_i is high, including across multiple strobes (bursts and read-modify-write).
REQ-020 GNTx with mx_cyc_i low: other master's cyc high -> GNT of the other master next cycle (no IDLE gap); otherwise -> IDLE.
REQ-021 last_gnt SHALL update on every entry to GNT0/GNT1.
REQ-022 The 8-bit timeout counter SHALL increment each cycle that s_stb_o=1 and s_ack_i=0 and s_err_i=0, and clear on ack, err, stb low, or a grant change.
REQ-023 When the counter equals TIMEOUT, the arbiter SHALL assert mx_err_o for exactly one cycle, force s_stb_o=0 in that cycle, clear the counter, and hold the grant.
REQ-024 If s_ack_i and s_err_i are both high, err SHALL take precedence: ack is passed as 0 and err as 1.
REQ-025 gnt_o SHALL be 2'b01 in GNT0, 2'b10 in GNT1, and 2'b00 in IDLE; busy_o = |gnt_o.

Reset
REQ-026 rst_i high SHALL immediately force IDLE, counter 0, last_gnt = master 1 (so m0 wins the first tie), and all s_*_o, ack/err outputs, gnt_o and busy_o to 0.
REQ-027 Reset asserted mid-transfer SHALL abort the transfer with no ack or err pulse; after release, arbitration restarts from IDLE on the first clock edge.

Verification
REQ-028 Both cyc rise in the same cycle after reset -> gnt_o=01 next cycle; m0 drops cyc -> gnt_o=10 the following cycle with no IDLE gap.
REQ-029 m1 holds cyc across 4 strobes/acks while m0 requests -> gnt_o stays 10 until m1_cyc_i falls; m0 sees no ack.
REQ-030 Slave never acks, TIMEOUT=8 -> m0_err_o pulses high exactly once, 8 stalled cycles after s_stb_o rises, with s_stb_o=0 in that cycle.
REQ-031 s_ack_i=1 and s_err_i=1 together -> granted err=1, ack=0; the other master sees 0/0.
REQ-032 rst_i pulsed during a GNT1 stall -> all outputs 0 within the same cycle; after release with only m0 requesting -> gnt_o=01 one cycle later.
